// File: rtl/stack_regfile_pkg.sv
// Shared encodings for the stack register file: stack request opcodes and
// controller FSM states.
package stack_regfile_pkg;

    typedef enum logic [1:0] {
        PUSH_REG = 2'd0,
        PUSH_PC  = 2'd1,
        POP_REG  = 2'd2,
        POP_PC   = 2'd3
    } st_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PUSH   = 2'd1,
        POP_RD = 2'd2,
        POP_WB = 2'd3
    } state_e;

endpackage

// File: rtl/stack_regfile_ram.sv
// Single-port stack storage: synchronous write, registered read of the same
// address (old data is returned when reading and writing together).
module stack_ram
    import stack_regfile_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset: stack contents survive a reset of the controller.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/stack_regfile.sv
// Small general register file with a hardware call/data stack that can push
// a register or the return PC and pop back into a register or onto ret_pc.
module stack_regfile
    import stack_regfile_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4,
    parameter int DEPTH    = 16,
    localparam int RSEL_W  = $clog2(NUM_REGS),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RSEL_W-1:0] rd_sel_a,
    input  logic [RSEL_W-1:0] rd_sel_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [RSEL_W-1:0] wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              st_valid,
    input  logic [1:0]        st_op,
    input  logic [RSEL_W-1:0] st_sel,
    input  logic [DATA_W-1:0] pc_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] ret_pc,
    output logic              ret_valid,
    output logic [DATA_W-1:0] sp,
    output logic [CNT_W-1:0]  count,
    output logic              ovf,
    output logic              udf,
    input  logic              clr_flags
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [DATA_W-1:0] DEPTH_D = DATA_W'(DEPTH);

    state_e            state;
    st_op_e            op_q;
    logic [RSEL_W-1:0] sel_q;
    logic [DATA_W-1:0] push_q;
    logic [DATA_W-1:0] ret_pc_q;
    logic              err_q;
    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] sp_up;
    logic              pop_wb_reg;
    logic              stack_full;
    logic              stack_empty;

    assign rd_data_a   = regs[rd_sel_a];
    assign rd_data_b   = regs[rd_sel_b];

    assign sp_up       = sp + 1'b1;
    assign stack_full  = (count == CNT_W'(DEPTH));
    assign stack_empty = (count == '0);

    // The RAM port writes the free slot at sp during PUSH and otherwise reads
    // the top entry at sp+1, which is what POP_RD needs.
    assign ram_we      = (state == PUSH);
    assign ram_addr    = ram_we ? AW'(sp % DEPTH_D) : AW'(sp_up % DEPTH_D);

    assign pop_wb_reg  = (state == POP_WB) && (op_q == POP_REG);
    assign busy        = (state != IDLE);
    assign done        = (state == PUSH) || (state == POP_WB) || err_q;
    assign err         = err_q;
    assign ret_valid   = (state == POP_WB) && (op_q == POP_PC);
    assign ret_pc      = ret_valid ? ram_rdata : ret_pc_q;

    stack_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (push_q),
        .rdata (ram_rdata)
    );

    // Controller. Overflow/underflow never leave IDLE; they only pulse err
    // (with done) and set the sticky flag, which takes priority over clr_flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= PUSH_REG;
            sel_q    <= '0;
            push_q   <= '0;
            ret_pc_q <= '0;
            err_q    <= 1'b0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
            sp       <= DATA_W'(DEPTH - 1);
            count    <= '0;
        end else begin
            err_q <= 1'b0;
            if (clr_flags) begin
                ovf <= 1'b0;
                udf <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (st_valid) begin
                        op_q   <= st_op_e'(st_op);
                        sel_q  <= st_sel;
                        push_q <= (st_op == PUSH_REG) ? regs[st_sel] : pc_in + 1'b1;
                        if (!st_op[1]) begin
                            if (stack_full) begin
                                ovf   <= 1'b1;
                                err_q <= 1'b1;
                            end else begin
                                state <= PUSH;
                            end
                        end else begin
                            if (stack_empty) begin
                                udf   <= 1'b1;
                                err_q <= 1'b1;
                            end else begin
                                state <= POP_RD;
                            end
                        end
                    end
                end
                PUSH: begin
                    sp    <= sp - 1'b1;
                    count <= count + 1'b1;
                    state <= IDLE;
                end
                POP_RD: begin
                    state <= POP_WB;
                end
                POP_WB: begin
                    sp    <= sp_up;
                    count <= count - 1'b1;
                    if (op_q == POP_PC) begin
                        ret_pc_q <= ram_rdata;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register file; a pop writeback is applied after the direct write so it
    // wins when both target the same register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                regs[wr_sel] <= wr_data;
            end
            if (pop_wb_reg) begin
                regs[sel_q] <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_stack_regfile.sv
// Scoreboard bench for stack_regfile: stimulus queues the expected completion,
// a negedge monitor checks every done pulse against it.
module tb_stack_regfile;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  rd_sel_a = '0, rd_sel_b = '0, wr_sel = '0, st_sel = '0, st_op = '0;
    logic [15:0] wr_data = '0, pc_in = '0;
    logic        wr_en = 1'b0, st_valid = 1'b0, clr_flags = 1'b0;
    logic [15:0] rd_data_a, rd_data_b, ret_pc, sp;
    logic [4:0]  count;
    logic        busy, done, err, ret_valid, ovf, udf;

    typedef struct {
        logic        err;
        logic        rv;
        logic [15:0] pc;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;

    stack_regfile dut (
        .clk       (clk),
        .reset     (reset),
        .rd_sel_a  (rd_sel_a),
        .rd_sel_b  (rd_sel_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .st_valid  (st_valid),
        .st_op     (st_op),
        .st_sel    (st_sel),
        .pc_in     (pc_in),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .ret_pc    (ret_pc),
        .ret_valid (ret_valid),
        .sp        (sp),
        .count     (count),
        .ovf       (ovf),
        .udf       (udf),
        .clr_flags (clr_flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                checkOutput({e.name, "_cycle"}, cyc, e.cyc);
                checkOutput({e.name, "_err"}, {31'd0, err}, {31'd0, e.err});
                checkOutput({e.name, "_ret_valid"}, {31'd0, ret_valid}, {31'd0, e.rv});
                if (e.rv) checkOutput({e.name, "_ret_pc"}, {16'd0, ret_pc}, {16'd0, e.pc});
            end
        end else if (ret_valid !== 1'b0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL stray_ret_valid: got ret_valid=%b without done, expected 0", ret_valid);
        end
    end

    // Issue one stack request at a negedge and wait (bounded) for it to finish.
    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] sel, input logic [15:0] pc,
                                 input logic exp_err, input logic exp_rv, input logic [15:0] exp_pc,
                                 input string name);
        exp_t e;
        int n;
        e.err  = exp_err;
        e.rv   = exp_rv;
        e.pc   = exp_pc;
        e.name = name;
        e.cyc  = cyc + ((exp_err || !op[1]) ? 1 : 2);
        sb.push_back(e);
        st_valid = 1'b1;
        st_op    = op;
        st_sel   = sel;
        pc_in    = pc;
        @(negedge clk);
        st_valid = 1'b0;
        wr_en    = 1'b0;
        n = 0;
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL %s_timeout: got busy=1 after 10 cycles, expected 0", name);
        end
    endtask

    task automatic directWrite(input logic [1:0] sel, input logic [15:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic readReg(input logic [1:0] sel, input logic [15:0] exp, input string name);
        rd_sel_a = sel;
        rd_sel_b = sel;
        #1;
        checkOutput({name, "_a"}, {16'd0, rd_data_a}, {16'd0, exp});
        checkOutput({name, "_b"}, {16'd0, rd_data_b}, {16'd0, exp});
    endtask

    task automatic checkStack(input logic [15:0] exp_sp, input logic [4:0] exp_cnt, input string name);
        checkOutput({name, "_sp"}, {16'd0, sp}, {16'd0, exp_sp});
        checkOutput({name, "_count"}, {27'd0, count}, {27'd0, exp_cnt});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;

        $display("[TB] reset state");
        checkStack(16'h000F, 5'd0, "reset");
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_flags", {30'd0, ovf, udf}, 32'd0);
        checkOutput("reset_ret_pc", {16'd0, ret_pc}, 32'd0);
        readReg(2'd1, 16'h0000, "reset_r1");

        $display("[TB] underflow on empty stack");
        applyStimulus(2'd2, 2'd2, 16'h0, 1'b1, 1'b0, 16'h0, "udf_pop");
        checkOutput("udf_flag", {31'd0, udf}, 32'd1);
        checkOutput("udf_no_ovf", {31'd0, ovf}, 32'd0);
        checkStack(16'h000F, 5'd0, "udf");
        readReg(2'd2, 16'h0000, "udf_r2");
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        checkOutput("udf_cleared", {31'd0, udf}, 32'd0);

        $display("[TB] push/pop register");
        directWrite(2'd1, 16'h1234);
        readReg(2'd1, 16'h1234, "direct_r1");
        wr_en = 1'b1; wr_sel = 2'd1; wr_data = 16'h5555;
        applyStimulus(2'd0, 2'd1, 16'h0, 1'b0, 1'b0, 16'h0, "push_r1");
        readReg(2'd1, 16'h5555, "r1_after_write");
        checkStack(16'h000E, 5'd1, "push_r1");
        applyStimulus(2'd2, 2'd2, 16'h0, 1'b0, 1'b0, 16'h0, "pop_r2");
        readReg(2'd2, 16'h1234, "pop_r2_val");
        checkStack(16'h000F, 5'd0, "pop_r2");

        $display("[TB] push/pop PC");
        applyStimulus(2'd1, 2'd0, 16'h00FF, 1'b0, 1'b0, 16'h0, "push_pc");
        applyStimulus(2'd3, 2'd0, 16'h0, 1'b0, 1'b1, 16'h0100, "pop_pc");
        checkStack(16'h000F, 5'd0, "pop_pc");
        checkOutput("ret_pc_held", {16'd0, ret_pc}, 32'h0100);

        $display("[TB] fill to overflow");
        for (int i = 0; i < 16; i++) applyStimulus(2'd1, 2'd0, 16'(i), 1'b0, 1'b0, 16'h0, "fill");
        checkStack(16'hFFFF, 5'd16, "full");
        applyStimulus(2'd0, 2'd1, 16'h0, 1'b1, 1'b0, 16'h0, "ovf_push");
        checkOutput("ovf_flag", {31'd0, ovf}, 32'd1);
        checkStack(16'hFFFF, 5'd16, "ovf");
        clr_flags = 1'b1;
        applyStimulus(2'd1, 2'd0, 16'h7777, 1'b1, 1'b0, 16'h0, "ovf_clr_push");
        clr_flags = 1'b0;
        checkOutput("ovf_set_wins", {31'd0, ovf}, 32'd1);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        checkOutput("ovf_cleared", {31'd0, ovf}, 32'd0);
        for (int i = 0; i < 16; i++) applyStimulus(2'd3, 2'd0, 16'h0, 1'b0, 1'b1, 16'(16 - i), "drain");
        checkStack(16'h000F, 5'd0, "drained");

        $display("[TB] writeback priority and busy ignore");
        applyStimulus(2'd0, 2'd1, 16'h0, 1'b0, 1'b0, 16'h0, "push_r1b");
        begin
            exp_t e;
            e.err = 1'b0; e.rv = 1'b0; e.pc = 16'h0; e.name = "pop_r0"; e.cyc = cyc + 2;
            sb.push_back(e);
        end
        st_valid = 1'b1; st_op = 2'd2; st_sel = 2'd0;
        @(negedge clk);
        st_op = 2'd0; st_sel = 2'd1;
        @(negedge clk);
        st_valid = 1'b0;
        wr_en = 1'b1; wr_sel = 2'd0; wr_data = 16'hAAAA;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        readReg(2'd0, 16'h5555, "pop_wins_r0");
        checkStack(16'h000F, 5'd0, "busy_ignored");

        $display("[TB] reset during POP_RD");
        applyStimulus(2'd0, 2'd1, 16'h0, 1'b0, 1'b0, 16'h0, "push_r1c");
        st_valid = 1'b1; st_op = 2'd3; st_sel = 2'd0;
        @(negedge clk);
        st_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkStack(16'h000F, 5'd0, "abort");
        repeat (3) @(negedge clk);
        checkOutput("abort_ret_pc", {16'd0, ret_pc}, 32'd0);

        checkOutput("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_regfile.md
STACK_REGFILE -- requirements
Module: stack_regfile

Interface
REQ-001 The block SHALL be clocked by one clock; reset is synchronous and active-high.
REQ-002 Parameter DATA_W, default 16, SHALL set register, stack-entry and PC width.
REQ-003 Parameter NUM_REGS, default 4, SHALL set the general register count; RSEL_W = clog2(NUM_REGS).
REQ-004 Parameter DEPTH, default 16, SHALL set stack entries (>=2); CNT_W = clog2(DEPTH+1).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 rd_sel_a, rd_sel_b  input  RSEL_W  combinational read-port selects.
REQ-008 rd_data_a, rd_data_b  output  DATA_W  register contents at the selects.
REQ-009 wr_en  input  1  direct register write strobe.
REQ-010 wr_sel, wr_data  input  RSEL_W, DATA_W  direct write target and value.
REQ-011 st_valid  input  1  stack request strobe.
REQ-012 st_op  input  2  PUSH_REG=0, PUSH_PC=1, POP_REG=2, POP_PC=3.
REQ-013 st_sel  input  RSEL_W  source register for PUSH_REG; destination for POP_REG.
REQ-014 pc_in  input  DATA_W  current PC for PUSH_PC.
REQ-015 busy  output  1  high while an accepted stack op is in flight.
REQ-016 done  output  1  one-cycle completion pulse; err  output  1  qualifies done.
REQ-017 ret_pc, ret_valid  output  DATA_W, 1  popped PC and its one-cycle valid.
REQ-018 sp  output  DATA_W  stack pointer; count  output  CNT_W  occupied entries.
REQ-019 ovf, udf  output  1  sticky overflow/underflow; clr_flags  input  1  clears both.

Function
REQ-020 Register reads SHALL be combinational; direct writes take effect at the next clk edge.
REQ-021 The FSM SHALL have states IDLE, PUSH, POP_RD, POP_WB.
REQ-022 st_valid SHALL be accepted only in IDLE; requests while busy are ignored, no queueing.
REQ-023 Push accepted at edge T: state PUSH in cycle T+1, entry written at sp, sp decrements, count increments, done=1 in T+1, IDLE in T+2.
REQ-024 PUSH_PC SHALL store pc_in+1 (mod 2^DATA_W), sampled at acceptance.
REQ-025 Pop accepted at T: POP_RD in T+1 reads entry sp+1 (synchronous RAM); POP_WB in T+2 writes the data to st_sel (POP_REG) or drives ret_pc with ret_valid=1 (POP_PC); sp increments, count decrements, done=1 in T+2.
REQ-026 Push with count==DEPTH SHALL write nothing, hold sp/count, set ovf, assert done and err in T+1.
REQ-027 Pop with count==0 SHALL write nothing, hold sp/count, set udf, assert done and err in T+1; ret_valid stays 0.
REQ-028 sp SHALL start at DEPTH-1; stack index = sp mod DEPTH; no wrap beyond DEPTH entries because REQ-026/027 block it.
REQ-029 Same-cycle POP_WB and wr_en to the same register: POP_WB value wins.
REQ-030 PUSH_REG source value SHALL be sampled at acceptance; later direct writes do not alter it.
REQ-031 clr_flags coinciding with an error SHALL leave the flag set (set wins).
REQ-032 busy = (state != IDLE); done, err, ret_valid are 0 outside the cycles above.

Reset
REQ-033 Reset SHALL force IDLE, sp=DEPTH-1, count=0, all registers 0, ovf=udf=done=err=ret_valid=0, ret_pc=0, aborting any in-flight op with no writeback.
REQ-034 Stack RAM contents SHALL NOT be cleared by reset.

Structure
REQ-035 Package stack_regfile_pkg SHALL hold the st_op encodings and FSM state encodings.
REQ-036 Stack storage SHALL be sub-module stack_ram (DEPTH x DATA_W, sync write, sync read, one port).

Verification
REQ-037 Reset, PUSH_REG r1=0x1234, POP_REG to r2 -> done at T+1 then T+2, r2=0x1234, sp back to 0x000F, count 0.
REQ-038 PUSH_PC pc_in=0x00FF, then POP_PC -> ret_valid=1 for one cycle with ret_pc=0x0100.
REQ-039 16 pushes then a 17th -> 17th has err=1, ovf=1, count=16, sp=0xFFFF unchanged; clr_flags -> ovf=0.
REQ-040 POP on empty after reset -> done+err at T+1, udf=1, no register changes.
REQ-041 POP_REG to r0 with wr_en r0=0xAAAA in POP_WB cycle -> r0 = popped value; st_valid while busy ignored.
REQ-042 reset asserted during POP_RD -> no writeback, IDLE, count=0, sp=0x000F next cycle.
